calc_ctrl: RTL and testbench

Multi-cycle operation controller for the calculator's single shared 8-bit ripple add/subtract datapath. It accepts one operation request at a time (ADD, SUB, MUL, DIV) with a start/busy/done handshake. It sequences the shared adder: one pass for ADD/SUB, or eight shift-add / restoring-subtract iterations for MUL/DIV. It sits between the keypad/operand registers and the result display logic.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_ctrl_if.sv | 32 +++
 rtl/calc_ctrl_add_sub8.sv | 35 +++
 rtl/calc_ctrl.sv | 158 +++++++++++++++
 tb/tb_calc_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared encodings for the calculator operation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ITER = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/calc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl_if
// Description : Request/response bundle between operand logic and calc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_ctrl_if #(
  parameter int W = 8
);

  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           overflow;
  logic           div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, overflow, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, overflow, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/calc_ctrl_add_sub8.sv
`default_nettype none
// ============================================================================
// Module      : add_sub8
// Description : Combinational ripple adder/subtractor (a + b, or a + ~b + 1).
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         overflow_o
);

  logic [W:0]   c;
  logic [W-1:0] bx;

  assign bx   = b_i ^ {W{sub_i}};
  assign c[0] = sub_i;

  generate
    for (genvar i = 0; i < W; i++) begin : g_ripple
      assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end
  endgenerate

  assign cout_o     = c[W];
  assign overflow_o = c[W] ^ c[W-1];

endmodule
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl
// Description : Sequences one shared adder for ADD/SUB (1 pass), MUL/DIV (W passes).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  calc_ctrl_if.slave  bus
);
  import calc_pkg::*;

  localparam int CNT_W = $clog2(ITER);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     acc_q, acc_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d;

  logic [W-1:0] add_x, add_y, add_sum;
  logic         add_sub, add_cout, add_ovf;
  logic         last_iter;
  logic [W-1:0] mul_hi, div_part;
  logic         mul_c, div_nob;
  logic [W-1:0] acc_nx, lo_nx;

  add_sub8 #(.W(W)) u_add (
    .a_i        (add_x),
    .b_i        (add_y),
    .sub_i      (add_sub),
    .sum_o      (add_sum),
    .cout_o     (add_cout),
    .overflow_o (add_ovf)
  );

  // Adder operand mux: the one adder serves whichever op is executing.
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_sub = (op_q == OP_SUB);
    if (op_q == OP_MUL) begin
      add_x   = acc_q;
      add_y   = a_q;
      add_sub = 1'b0;
    end else if (op_q == OP_DIV) begin
      add_x   = div_part;
      add_y   = b_q;
      add_sub = 1'b1;
    end
  end

  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign mul_hi    = lo_q[0] ? add_sum : acc_q;
  assign mul_c     = lo_q[0] & add_cout;
  // Remainder stays below b, so only its bit W-1 can extend the 9-bit compare.
  assign div_part  = {acc_q[W-2:0], lo_q[W-1]};
  assign div_nob   = acc_q[W-1] | add_cout;

  always_comb begin
    acc_nx = {mul_c, mul_hi[W-1:1]};
    lo_nx  = {mul_hi[0], lo_q[W-1:1]};
    if (op_q == OP_DIV) begin
      acc_nx = div_nob ? add_sum : div_part;
      lo_nx  = {lo_q[W-2:0], div_nob};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_EXEC;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          lo_d    = (bus.op == OP_MUL) ? bus.b : bus.a;
          cnt_d   = '0;
          res_d   = '0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          res_d   = {{W{add_sum[W-1]}}, add_sum};
          ovf_d   = add_ovf;
          state_d = ST_DONE;
        end else if (op_q == OP_DIV && cnt_q == '0 && b_q == '0) begin
          res_d   = {a_q, {W{1'b1}}};
          dbz_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_d = acc_nx;
          lo_d  = lo_nx;
          if (last_iter) begin
            res_d   = {acc_nx, lo_nx};
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ST_EXEC);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.result      = res_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_ctrl
// Description : Directed self-checking bench for calc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;
  import calc_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   cyc;

  calc_ctrl_if #(.W(8)) bus ();

  calc_ctrl #(.W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 1 is the first cycle after the accepting edge; samples are on negedges.
  task automatic do_start(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.result, bus.overflow, bus.div_by_zero} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {bus.busy, bus.done, bus.result, bus.overflow, bus.div_by_zero});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    do_start(OP_ADD, 8'h7F, 8'h01);
    goto(1);
    total++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      bad++; $display("FAIL add_c1_busy_done got=%b exp=10", {bus.busy, bus.done});
    end
    goto(2);
    total++;
    if ({bus.busy, bus.done, bus.result, bus.overflow} !== {2'b01, 16'hFF80, 1'b1}) begin
      bad++; $display("FAIL add_c2 busy/done/result/ovf got=%b/%b/%h/%b exp=0/1/ff80/1",
                      bus.busy, bus.done, bus.result, bus.overflow);
    end
    goto(3);
    total++;
    if ({bus.done, bus.result, bus.overflow} !== {1'b0, 16'hFF80, 1'b1}) begin
      bad++; $display("FAIL add_hold done/result/ovf got=%b/%h/%b exp=0/ff80/1",
                      bus.done, bus.result, bus.overflow);
    end
  endtask

  task automatic test_sub;
    do_start(OP_SUB, 8'h05, 8'h07);
    goto(2);
    total++;
    if ({bus.done, bus.result, bus.overflow} !== {1'b1, 16'hFFFE, 1'b0}) begin
      bad++; $display("FAIL sub_5_7 done/result/ovf got=%b/%h/%b exp=1/fffe/0",
                      bus.done, bus.result, bus.overflow);
    end
    do_start(OP_SUB, 8'h80, 8'h01);
    goto(2);
    total++;
    if ({bus.done, bus.result, bus.overflow} !== {1'b1, 16'h007F, 1'b1}) begin
      bad++; $display("FAIL sub_80_1 done/result/ovf got=%b/%h/%b exp=1/007f/1",
                      bus.done, bus.result, bus.overflow);
    end
  endtask

  task automatic test_mul;
    int busy_ok;
    busy_ok = 1;
    do_start(OP_MUL, 8'hFF, 8'hFF);
    for (int k = 1; k <= 8; k++) begin
      goto(k);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 0;
    end
    total++;
    if (busy_ok != 1) begin
      bad++; $display("FAIL mul_busy_window got=not-busy-in-1..8 exp=busy");
    end
    goto(9);
    total++;
    if ({bus.busy, bus.done, bus.result, bus.overflow} !== {2'b01, 16'hFE01, 1'b0}) begin
      bad++; $display("FAIL mul_ff_ff busy/done/result/ovf got=%b/%b/%h/%b exp=0/1/fe01/0",
                      bus.busy, bus.done, bus.result, bus.overflow);
    end
    do_start(OP_MUL, 8'h0D, 8'h0B);
    goto(9);
    total++;
    if ({bus.done, bus.result} !== {1'b1, 16'h008F}) begin
      bad++; $display("FAIL mul_0d_0b done/result got=%b/%h exp=1/008f", bus.done, bus.result);
    end
  endtask

  task automatic test_div;
    do_start(OP_DIV, 8'd200, 8'd7);
    goto(8);
    total++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      bad++; $display("FAIL div_c8_busy_done got=%b exp=10", {bus.busy, bus.done});
    end
    goto(9);
    total++;
    if ({bus.done, bus.result, bus.div_by_zero} !== {1'b1, 16'h041C, 1'b0}) begin
      bad++; $display("FAIL div_200_7 done/result/dbz got=%b/%h/%b exp=1/041c/0",
                      bus.done, bus.result, bus.div_by_zero);
    end
    do_start(OP_DIV, 8'hFF, 8'h81);
    goto(9);
    total++;
    if ({bus.done, bus.result} !== {1'b1, 16'h7E01}) begin
      bad++; $display("FAIL div_ff_81 done/result got=%b/%h exp=1/7e01", bus.done, bus.result);
    end
  endtask

  task automatic test_div_zero;
    do_start(OP_DIV, 8'hC8, 8'h00);
    goto(1);
    total++;
    if ({bus.busy, bus.result, bus.div_by_zero} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL dbz_c1 busy/result/dbz got=%b/%h/%b exp=1/0000/0",
                      bus.busy, bus.result, bus.div_by_zero);
    end
    goto(2);
    total++;
    if ({bus.busy, bus.done, bus.result, bus.div_by_zero} !== {2'b01, 16'hC8FF, 1'b1}) begin
      bad++; $display("FAIL dbz_c2 busy/done/result/dbz got=%b/%b/%h/%b exp=0/1/c8ff/1",
                      bus.busy, bus.done, bus.result, bus.div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    do_start(OP_MUL, 8'h12, 8'h34);
    goto(3);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    @(posedge clk);
    #1 bus.start = 1'b0;
    goto(4);
    total++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      bad++; $display("FAIL ignore_c4_busy_done got=%b exp=10", {bus.busy, bus.done});
    end
    goto(9);
    total++;
    if ({bus.done, bus.result} !== {1'b1, 16'h03A8}) begin
      bad++; $display("FAIL ignore_result done/result got=%b/%h exp=1/03a8", bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid;
    do_start(OP_MUL, 8'hFF, 8'hFF);
    goto(4);
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.result, bus.overflow, bus.div_by_zero} !== 20'h0) begin
      bad++; $display("FAIL midreset_outputs got=%h exp=0",
                      {bus.busy, bus.done, bus.result, bus.overflow, bus.div_by_zero});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.result} !== 18'h0) begin
      bad++; $display("FAIL midreset_idle busy/done/result got=%b/%b/%h exp=0/0/0000",
                      bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_back_to_back;
    do_start(OP_ADD, 8'h01, 8'h02);
    goto(2);
    total++;
    if ({bus.done, bus.result} !== {1'b1, 16'h0003}) begin
      bad++; $display("FAIL b2b_first done/result got=%b/%h exp=1/0003", bus.done, bus.result);
    end
    bus.start = 1'b1;
    bus.op    = OP_SUB;
    bus.a     = 8'h03;
    bus.b     = 8'h01;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    goto(1);
    total++;
    if ({bus.busy, bus.done, bus.result} !== {2'b10, 16'h0000}) begin
      bad++; $display("FAIL b2b_accept busy/done/result got=%b/%b/%h exp=1/0/0000",
                      bus.busy, bus.done, bus.result);
    end
    goto(2);
    total++;
    if ({bus.done, bus.result, bus.overflow} !== {1'b1, 16'h0002, 1'b0}) begin
      bad++; $display("FAIL b2b_second done/result/ovf got=%b/%h/%b exp=1/0002/0",
                      bus.done, bus.result, bus.overflow);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
